uart_rx_framed: RTL

UART_RX_FRAMED -- requirements
Module: uart_rx_framed

---
 rtl/uart_rx_framed.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_framed.sv
// Framed UART receiver: 2-flop sync, 8N1-style framing, optional parity via `UART_RX_PARITY_EN.
// Latency: RX_Valid rises one cycle after the final stop-bit centre sample.
// Backpressure: one held byte; a frame completing while the held byte is unaccepted is dropped and RX_Overrun pulses.
module uart_rx_framed #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 RX_Serial,
  input  logic                 RX_Ready,
  output logic                 RX_Valid,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 RX_Frame_Err,
  output logic                 RX_Parity_Err,
  output logic                 RX_Overrun,
  output logic                 RX_Busy
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF      = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q;
  logic                   rx_s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   ferr_q, ferr_d;
  logic                   done_q, done_d;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q, perr_d;
`endif

  assign rx_s    = sync_q[1];
  assign RX_Busy = (state_q != ST_IDLE);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[0], RX_Serial};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
          bit_d   = '0;
          ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          // a start bit that is high again at mid-bit was only a glitch
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          perr_d  = ((^shreg_q) ^ rx_s) != (PARITY_ODD != 0);
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~rx_s;
          if (bit_q == STOP_LAST) begin
            // leave at the centre sample so a back-to-back start edge is not missed
            state_d = ST_IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      RX_Valid     <= 1'b0;
      RX_Data      <= '0;
      RX_Frame_Err <= 1'b0;
      RX_Overrun   <= 1'b0;
    end else begin
      RX_Overrun <= 1'b0;
      if (done_q && (!RX_Valid || RX_Ready)) begin
        RX_Valid     <= 1'b1;
        RX_Data      <= shreg_q;
        RX_Frame_Err <= ferr_q;
      end else begin
        if (done_q) RX_Overrun <= 1'b1;
        if (RX_Valid && RX_Ready) RX_Valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      RX_Parity_Err <= 1'b0;
    end else if (done_q && (!RX_Valid || RX_Ready)) begin
      RX_Parity_Err <= perr_q;
    end
  end
`else
  assign RX_Parity_Err = 1'b0;
`endif

endmodule
